// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and
// emits them one bit per bit_en strobe, back-to-back words with no gap.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no word loaded; dout = IDLE_LEVEL, ready for a new word
// ST_SHIFT | word in flight; dout = output end of the shift register
module piso_bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dout, r_dout_valid;
  logic             w_cnt_last, w_in_ready, w_accept, w_out_bit;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_in_ready  = 1'b0;
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_IDLE:  w_in_ready = 1'b1;
      ST_SHIFT: w_in_ready = bit_en & w_cnt_last;
      default:  w_in_ready = 1'b0;
    endcase

    w_accept = in_valid & w_in_ready;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_en) begin
          if (!w_cnt_last) begin
            if (MSB_FIRST) w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
            else           w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
            w_cnt_nxt = r_cnt + CW'(1);
          end else if (w_accept) begin
            // Reload on the last bit so the next word follows with no gap.
            w_shift_nxt = in_data;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_out_bit = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= IDLE_LEVEL;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= (w_state_nxt == ST_SHIFT) ? w_out_bit : IDLE_LEVEL;
      r_dout_valid <= (w_state_nxt == ST_SHIFT);
    end
  end

  assign in_ready   = w_in_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign last_bit   = r_dout_valid & w_cnt_last;

endmodule
